// File: rtl/horner_poly_pipe.sv
// Fully pipelined Q16 Horner polynomial evaluator with runtime coefficients,
// optional cutoff gating and valid/ready handshakes on input and output.
module horner_poly_pipe #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEG        = 7,
  localparam int CA_W       = $clog2(DEG + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_r,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_y,
  output logic                  out_gated,
  input  logic                  coef_we,
  input  logic [CA_W-1:0]       coef_addr,
  input  logic [31:0]           coef_wdata,
  input  logic                  cut_we,
  input  logic                  cut_en_d,
  input  logic [DATA_WIDTH-1:0] cut_wdata,
  output logic                  busy,
  output logic                  coef_err
);

  localparam int PW = DATA_WIDTH + 33;

  // Signed coefficient times unsigned Q16 sample, floor-shifted back to Q16.
  function automatic logic [31:0] mul_q16(input logic [31:0] a, input logic [DATA_WIDTH-1:0] b);
    logic signed [PW-1:0] p;
    p = $signed(PW'($signed(a))) * $signed(PW'(b));
    return 32'(p >>> 16);
  endfunction

  logic [31:0]           coef_reg  [0:DEG];
  logic                  valid_reg [0:DEG];
  logic                  gated_reg [0:DEG];
  logic [31:0]           acc_reg   [0:DEG];
  logic [DATA_WIDTH-1:0] x_reg     [0:DEG-1];
  logic                  cut_en_reg;
  logic [DATA_WIDTH-1:0] cutoff_reg;
  logic                  coef_err_reg;

  logic en;
  logic accept;
  logic addr_ok;
  logic write_ok;

  assign en       = !valid_reg[DEG] || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign write_ok = coef_we && !busy && !accept && addr_ok;

  // When DEG+1 fills the address space every address is a legal index.
  if ((1 << CA_W) > DEG + 1) begin : g_addr_chk
    assign addr_ok = (coef_addr <= CA_W'(DEG));
  end else begin : g_addr_all
    assign addr_ok = 1'b1;
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= DEG; i++) begin
      busy = busy | valid_reg[i];
    end
  end

  assign out_valid = valid_reg[DEG];
  assign out_gated = gated_reg[DEG];
  assign out_y     = gated_reg[DEG] ? 32'd0 : acc_reg[DEG];
  assign coef_err  = coef_err_reg;

  for (genvar gi = 0; gi <= DEG; gi++) begin : g_coef
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        coef_reg[gi] <= 32'd0;
      end else if (write_ok && (coef_addr == CA_W'(gi))) begin
        coef_reg[gi] <= coef_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_err_reg <= 1'b0;
      cut_en_reg   <= 1'b0;
      cutoff_reg   <= '1;
    end else begin
      coef_err_reg <= coef_we && !write_ok;
      if (cut_we) begin
        cut_en_reg <= cut_en_d;
        cutoff_reg <= cut_wdata;
      end
    end
  end

  // Stage 0 samples the cutoff registers before any same-edge cutoff write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg[0] <= 1'b0;
      gated_reg[0] <= 1'b0;
      acc_reg[0]   <= 32'd0;
      x_reg[0]     <= '0;
    end else if (en) begin
      valid_reg[0] <= accept;
      gated_reg[0] <= cut_en_reg && (in_r > cutoff_reg);
      acc_reg[0]   <= coef_reg[DEG];
      x_reg[0]     <= in_r;
    end
  end

  for (genvar gi = 1; gi <= DEG; gi++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg[gi] <= 1'b0;
        gated_reg[gi] <= 1'b0;
        acc_reg[gi]   <= 32'd0;
      end else if (en) begin
        valid_reg[gi] <= valid_reg[gi-1];
        gated_reg[gi] <= gated_reg[gi-1];
        acc_reg[gi]   <= mul_q16(acc_reg[gi-1], x_reg[gi-1]) + coef_reg[DEG-gi];
      end
    end

    if (gi < DEG) begin : g_x
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_reg[gi] <= '0;
        end else if (en) begin
          x_reg[gi] <= x_reg[gi-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_horner_poly_pipe.sv
// Randomised and directed checks of horner_poly_pipe against a behavioural
// polynomial model and an in-order scoreboard.
module tb_horner_poly_pipe;

  localparam int DEG  = 7;
  localparam int DW   = 16;
  localparam int CA_W = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_r;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_y;
  logic            out_gated;
  logic            coef_we;
  logic [CA_W-1:0] coef_addr;
  logic [31:0]     coef_wdata;
  logic            cut_we;
  logic            cut_en_d;
  logic [DW-1:0]   cut_wdata;
  logic            busy;
  logic            coef_err;

  horner_poly_pipe #(.DATA_WIDTH(DW), .DEG(DEG)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_gated(out_gated),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .cut_we(cut_we), .cut_en_d(cut_en_d), .cut_wdata(cut_wdata),
    .busy(busy), .coef_err(coef_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic        g;
    int          cyc;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          inflight = 0;
  int          n_out   = 0;
  exp_t        sb[$];
  logic [31:0] m_coef [0:DEG];
  logic        m_cut_en;
  logic [DW-1:0] m_cutoff;
  logic        err_exp;
  logic        hold_pending;
  logic [31:0] hold_y;
  logic        hold_g;
  logic [31:0] last_y;
  logic        last_g;
  int          last_lat;
  logic        last_acc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [DW-1:0] b);
    longint p;
    p = longint'(signed'(a)) * longint'({48'd0, b});
    return 32'(p >>> 16);
  endfunction

  // y = c[0] + r*(c[1] + r*(... + r*c[DEG])), each product floored to Q16.
  function automatic exp_t model_eval(input logic [DW-1:0] r);
    exp_t e;
    logic [31:0] acc;
    acc = m_coef[DEG];
    for (int k = DEG - 1; k >= 0; k--) acc = model_mul(acc, r) + m_coef[k];
    e.g   = m_cut_en && (r > m_cutoff);
    e.y   = e.g ? 32'd0 : acc;
    e.cyc = cyc;
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k <= DEG; k++) m_coef[k] = 32'd0;
    m_cut_en = 1'b0;
    m_cutoff = '1;
    sb.delete();
    inflight = 0;
    err_exp = 1'b0;
    hold_pending = 1'b0;
  endtask

  // One clock cycle: inputs already driven after the previous negedge.
  task automatic tick();
    exp_t e;
    logic wr_ok;
    #1;
    check_val("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    check_val("busy", 32'(busy), 32'(inflight != 0));
    check_val("coef_err", 32'(coef_err), 32'(err_exp));
    if (hold_pending) begin
      check_val("hold_valid", 32'(out_valid), 32'd1);
      check_val("hold_y", out_y, hold_y);
      check_val("hold_gated", 32'(out_gated), 32'(hold_g));
    end
    wr_ok = coef_we && (inflight == 0) && !(in_valid && in_ready) && (int'(coef_addr) <= DEG);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_val("spurious_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("out_y", out_y, e.y);
        check_val("out_gated", 32'(out_gated), 32'(e.g));
        last_y   = out_y;
        last_g   = out_gated;
        last_lat = cyc - e.cyc;
        inflight--;
        n_out++;
        $display("[TB] out #%0d y=%h gated=%0d", n_out, out_y, out_gated);
      end
    end
    hold_pending = out_valid && !out_ready;
    hold_y = out_y;
    hold_g = out_gated;
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      sb.push_back(model_eval(in_r));
      inflight++;
    end
    if (wr_ok) m_coef[coef_addr] = coef_wdata;
    err_exp = coef_we && !wr_ok;
    if (cut_we) begin
      m_cut_en = cut_en_d;
      m_cutoff = cut_wdata;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    coef_we  = 1'b0;
    cut_we   = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] r);
    int tries;
    tries = 0;
    in_valid = 1'b1;
    in_r = r;
    do begin
      tick();
      tries++;
    end while (!last_acc && tries < 50);
    if (!last_acc) check_val("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    out_ready = 1'b1;
    while (inflight != 0 && n < 100) begin
      tick();
      n++;
    end
    if (inflight != 0) check_val("drain_timeout", 32'(inflight), 32'd0);
  endtask

  task automatic wcoef(input logic [CA_W-1:0] a, input logic [31:0] d);
    coef_we = 1'b1;
    coef_addr = a;
    coef_wdata = d;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic wcut(input logic en, input logic [DW-1:0] v);
    cut_we = 1'b1;
    cut_en_d = en;
    cut_wdata = v;
    tick();
    cut_we = 1'b0;
  endtask

  initial begin
    int sent;
    logic [DW-1:0] rv [0:19];
    rst_n = 1'b0;
    idle();
    in_r = '0;
    out_ready = 1'b1;
    coef_addr = '0;
    coef_wdata = '0;
    cut_en_d = 1'b0;
    cut_wdata = '0;
    last_y = '0;
    last_g = 1'b0;
    last_lat = 0;
    last_acc = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_y", out_y, 32'd0);
    check_val("rst_out_gated", 32'(out_gated), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_coef_err", 32'(coef_err), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Reset in the middle of traffic with coef_err raised.
    wcoef(3'd0, 32'h0001_0000);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_r = 16'(i * 1000 + 7);
      tick();
    end
    idle();
    wcoef(3'd2, 32'h0000_1234);
    check_val("pre_rst_coef_err", 32'(coef_err), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", 32'(out_valid), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_coef_err", 32'(coef_err), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h8000);
    drain();
    check_val("t1_y_zero", last_y, 32'd0);

    // Known value and latency.
    wcoef(3'd1, 32'h0001_0000);
    wcoef(3'd0, 32'h0001_0000);
    send(16'h8000);
    drain();
    check_val("t2_y", last_y, 32'h0001_8000);
    check_val("t2_latency_ticks", 32'(last_lat), 32'(DEG + 1));

    // Cutoff gating, strict compare, and same-edge cutoff write.
    wcut(1'b1, 16'h4000);
    send(16'h8000);
    drain();
    check_val("t4_gated_y", last_y, 32'd0);
    check_val("t4_gated_g", 32'(last_g), 32'd1);
    send(16'h4000);
    drain();
    check_val("t4_eq_y", last_y, 32'h0001_4000);
    check_val("t4_eq_g", 32'(last_g), 32'd0);
    cut_we = 1'b1;
    cut_en_d = 1'b0;
    cut_wdata = 16'hFFFF;
    send(16'h8000);
    cut_we = 1'b0;
    drain();
    check_val("t4_old_cut_g", 32'(last_g), 32'd1);
    send(16'h8000);
    drain();
    check_val("t4_new_cut_y", last_y, 32'h0001_8000);

    // Coefficient guard: write while busy, and write on an accepting edge.
    send(16'h8000);
    wcoef(3'd0, 32'h0001_2345);
    check_val("t5_busy_err_hi", 32'(coef_err), 32'd1);
    tick();
    check_val("t5_busy_err_lo", 32'(coef_err), 32'd0);
    drain();
    in_valid = 1'b1;
    in_r = 16'h8000;
    wcoef(3'd0, 32'h0005_0000);
    in_valid = 1'b0;
    check_val("t5_acc_err_hi", 32'(coef_err), 32'd1);
    tick();
    check_val("t5_acc_err_lo", 32'(coef_err), 32'd0);
    drain();
    check_val("t5_c_unchanged", last_y, 32'h0001_8000);

    // Two's complement wrap.
    wcoef(3'd0, 32'h7FFF_FFFF);
    send(16'h8000);
    drain();
    check_val("t6_wrap", last_y, 32'h8000_7FFF);

    // Random coefficients, then 20 back-to-back samples with a 5-cycle stall.
    for (int k = 0; k <= DEG; k++) wcoef(CA_W'(k), $urandom);
    for (int i = 0; i < 20; i++) rv[i] = 16'($urandom);
    n_out = 0;
    sent = 0;
    for (int c = 0; c < 100 && sent < 20; c++) begin
      in_valid = 1'b1;
      in_r = rv[sent];
      out_ready = !(c >= 10 && c < 15);
      tick();
      if (last_acc) sent++;
    end
    drain();
    check_val("t3_count", 32'(n_out), 32'd20);

    // Random soak: random handshakes, cutoff and coefficient writes.
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_r = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      coef_we = ($urandom_range(0, 15) == 0);
      coef_addr = CA_W'($urandom);
      coef_wdata = $urandom;
      cut_we = ($urandom_range(0, 19) == 0);
      cut_en_d = 1'($urandom);
      cut_wdata = 16'($urandom);
      tick();
      if (c % 50 == 49) begin
        drain();
        wcoef(CA_W'($urandom), $urandom);
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
